aes_round_ops: RTL and testbench
================================

Name: aes_round_ops

Overview:
- AES-128 round-operation unit used by the encryption controller.
- Provides three independently enabled, registered sub-operations on 128-bit states:
  - AddRoundKey (ARK)
  - single-step key expansion (KEXP)
  - MixColumns (MC)
- The controller sequences rounds by pulsing/holding enables and waiting on done flags.

Parameters:
None.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ark_en  in  1  enable AddRoundKey.
- ark_state_in  in  128  state operand.
- ark_key_in  in  128  round key operand.
- ark_out  out  128  registered state XOR key.
- ark_done  out  1  ARK result valid.
- kexp_en  in  1  enable key expansion step.
- kexp_key_in  in  128  previous round key.
- kexp_num  in  4  round number of key to produce (1..10).
- kexp_out  out  128  registered next round key.
- mc_en  in  1  enable MixColumns.
- mc_in  in  128  state operand.
- mc_out  out  128  registered MixColumns result.
- mc_done  out  1  MC result valid.

Behaviour:
- Byte order (all 128-bit ports): byte[r][c] = bits [127-8*(4c+r) -: 8]. Column c is bits [127-32c -: 32], with row 0 as MSB byte.
- Reset (reset=1 at edge) clears all of the following; reset has priority over every enable:
  - ark_out, kexp_out, mc_out to 0.
  - ark_done, mc_done to 0.
- ARK:
  - Edge with ark_en=1: ark_out <= ark_state_in ^ ark_key_in, and ark_done <= 1.
  - Edge with ark_en=0: ark_done <= 0 and ark_out holds.
  - Latency: 1 cycle; operands are resampled every enabled cycle.
  - ark_done remains 1 while ark_en is held high.
- KEXP:
  - Edge with kexp_en=1 and kexp_num in 1..10: kexp_out <= FIPS-197 next round key of kexp_key_in.
    - w = 32-bit words, w0 = MSB word.
    - t = SubWord(RotWord(w3)) ^ {Rcon[kexp_num], 24'h0}.
    - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
    - o0 = w0^t, o1 = w1^o0, o2 = w2^o1, o3 = w3^o2.
  - kexp_num = 0 or 11..15: kexp_out <= kexp_key_in (pass-through).
  - kexp_en = 0: kexp_out holds.
  - No done flag: output is valid 1 cycle after the enabled edge.
  - S-box is the standard AES forward S-box (combinational table, 4 instances).
- MC:
  - Edge with mc_en=1: each column (a0..a3) is transformed to:
    - b0 = 2a0^3a1^a2^a3
    - b1 = a0^2a1^3a2^a3
    - b2 = a0^a1^2a2^3a3
    - b3 = 3a0^a1^a2^2a3
  - GF(2^8) arithmetic: 2x = xtime (shift left, XOR 1b if MSB was set), 3x = 2x^x.
  - mc_done <= 1 on the same edge.
  - Edge with mc_en=0: mc_done <= 0 and mc_out holds.
- The three sub-operations are fully independent and may be enabled in the same cycle.
- No internal state machine beyond the done flags.
- Reset mid-operation: outputs and dones are 0 on the next cycle, and the operation is not resumed.

Test Plan:
- ARK: ark_en=1 for one cycle with state 3243f6a8885a308d313198a2e0370734 and key 2b7e151628aed2a6abf7158809cf4f3c.
  - Next cycle: ark_out = 193de3bea0f4e22b9ac68d2ae9f84808 and ark_done = 1.
  - After ark_en drops: ark_done = 0 one cycle later and ark_out holds.
- KEXP chain: kexp_key_in = 2b7e151628aed2a6abf7158809cf4f3c, kexp_num = 1 → a0fafe1788542cb123a339392a6c7605.
  - Feed back each output with num 2..10; the final kexp_out = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - kexp_num = 0 → output equals input.
- MC: mc_in = d4bf5d30e0b452aeb84111f11e2798e5 → mc_out = 046681e5e0cb199a48f8d37a2806264c, mc_done = 1.
  - Single column db135345 → 8e4da1bc.
  - Columns 01010101 and c6c6c6c6 map to themselves.
- Combined round: ARK of 046681e5e0cb199a48f8d37a2806264c with a0fafe1788542cb123a339392a6c7605 → a49c7ff2689f352b6b5bea43026a5049.
  - Assert all three enables in the same cycle and check all results together.
- Reset: assert reset while all enables are high.
  - Next cycle: all outputs = 0 and all dones = 0.
  - Release reset with enables high: results appear one cycle later.

Source files
------------

// File: rtl/aes_round_ops.sv
// AES-128 round-operation unit: AddRoundKey, single-step key expansion and
// MixColumns, each an independently enabled, registered datapath.
module aes_round_ops (
  input  logic         clk,
  input  logic         reset,
  input  logic         ark_en,
  input  logic [127:0] ark_state_in,
  input  logic [127:0] ark_key_in,
  output logic [127:0] ark_out,
  output logic         ark_done,
  input  logic         kexp_en,
  input  logic [127:0] kexp_key_in,
  input  logic [3:0]   kexp_num,
  output logic [127:0] kexp_out,
  input  logic         mc_en,
  input  logic [127:0] mc_in,
  output logic [127:0] mc_out,
  output logic         mc_done
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] num);
    case (num)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column, row 0 in the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [127:0] ark_out_d, ark_out_q;
  logic         ark_done_d, ark_done_q;
  logic [127:0] kexp_out_d, kexp_out_q;
  logic [127:0] mc_out_d, mc_out_q;
  logic         mc_done_d, mc_done_q;

  logic [31:0]  kexp_rot, kexp_t;
  logic [31:0]  kexp_o0, kexp_o1, kexp_o2, kexp_o3;
  logic         kexp_num_valid;

  always_comb begin
    kexp_rot = {kexp_key_in[23:0], kexp_key_in[31:24]};
    kexp_t   = {sbox(kexp_rot[31:24]), sbox(kexp_rot[23:16]),
                sbox(kexp_rot[15:8]),  sbox(kexp_rot[7:0])}
             ^ {rcon(kexp_num), 24'h0};
    kexp_o0  = kexp_key_in[127:96] ^ kexp_t;
    kexp_o1  = kexp_key_in[95:64]  ^ kexp_o0;
    kexp_o2  = kexp_key_in[63:32]  ^ kexp_o1;
    kexp_o3  = kexp_key_in[31:0]   ^ kexp_o2;
    kexp_num_valid = (kexp_num >= 4'd1) && (kexp_num <= 4'd10);
  end

  always_comb begin
    // NOTE: every _d starts from the held value so no path leaves it unassigned (no latches).
    ark_out_d  = ark_out_q;
    kexp_out_d = kexp_out_q;
    mc_out_d   = mc_out_q;
    ark_done_d = ark_en;
    mc_done_d  = mc_en;
    if (ark_en) ark_out_d = ark_state_in ^ ark_key_in;
    if (kexp_en) kexp_out_d = kexp_num_valid ? {kexp_o0, kexp_o1, kexp_o2, kexp_o3}
                                             : kexp_key_in;
    if (mc_en) mc_out_d = {mix_column(mc_in[127:96]), mix_column(mc_in[95:64]),
                           mix_column(mc_in[63:32]),  mix_column(mc_in[31:0])};
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ark_out_q  <= '0;
      ark_done_q <= 1'b0;
      kexp_out_q <= '0;
      mc_out_q   <= '0;
      mc_done_q  <= 1'b0;
    end else begin
      ark_out_q  <= ark_out_d;
      ark_done_q <= ark_done_d;
      kexp_out_q <= kexp_out_d;
      mc_out_q   <= mc_out_d;
      mc_done_q  <= mc_done_d;
    end
  end

  assign ark_out  = ark_out_q;
  assign ark_done = ark_done_q;
  assign kexp_out = kexp_out_q;
  assign mc_out   = mc_out_q;
  assign mc_done  = mc_done_q;

endmodule

// File: tb/tb_aes_round_ops.sv
// Scoreboard bench for aes_round_ops: expectations are queued when stimulus is
// driven and compared one cycle later, after the capturing edge.
module tb_aes_round_ops;

  logic         clk = 1'b0;
  logic         reset;
  logic         ark_en, kexp_en, mc_en;
  logic [127:0] ark_state_in, ark_key_in, kexp_key_in, mc_in;
  logic [3:0]   kexp_num;
  logic [127:0] ark_out, kexp_out, mc_out;
  logic         ark_done, mc_done;

  aes_round_ops dut (
    .clk(clk), .reset(reset),
    .ark_en(ark_en), .ark_state_in(ark_state_in), .ark_key_in(ark_key_in),
    .ark_out(ark_out), .ark_done(ark_done),
    .kexp_en(kexp_en), .kexp_key_in(kexp_key_in), .kexp_num(kexp_num),
    .kexp_out(kexp_out),
    .mc_en(mc_en), .mc_in(mc_in), .mc_out(mc_out), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  typedef enum int {SEL_ARK, SEL_ARK_DONE, SEL_KEXP, SEL_MC, SEL_MC_DONE} sel_e;
  typedef struct {
    string        tag;
    sel_e         sel;
    logic [127:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ARK0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] MC_I  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] MC_O  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] RND1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] COL_I = 128'hdb13534501010101c6c6c6c6f20a225c;
  localparam logic [127:0] COL_O = 128'h8e4da1bc01010101c6c6c6c69fdc589d;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input sel_e sel, input logic [127:0] value);
    exp_t e;
    e.tag = tag; e.sel = sel; e.value = value;
    sb.push_back(e);
  endtask

  function automatic logic [127:0] observe(input sel_e sel);
    case (sel)
      SEL_ARK:      return ark_out;
      SEL_ARK_DONE: return {127'h0, ark_done};
      SEL_KEXP:     return kexp_out;
      SEL_MC:       return mc_out;
      default:      return {127'h0, mc_done};
    endcase
  endfunction

  // Advance one edge, then retire every expectation queued for it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.value);
    end
  endtask

  initial begin
    reset = 1'b1;
    ark_en = 1'b0; kexp_en = 1'b0; mc_en = 1'b0;
    ark_state_in = '0; ark_key_in = '0; kexp_key_in = '0; mc_in = '0; kexp_num = '0;
    expect_out("rst_ark", SEL_ARK, '0);
    expect_out("rst_ark_done", SEL_ARK_DONE, '0);
    expect_out("rst_kexp", SEL_KEXP, '0);
    expect_out("rst_mc", SEL_MC, '0);
    expect_out("rst_mc_done", SEL_MC_DONE, '0);
    tick();
    reset = 1'b0;
    tick();

    // ARK single pulse, then hold after the enable drops.
    ark_en = 1'b1; ark_state_in = PT; ark_key_in = KEY0;
    expect_out("ark_val", SEL_ARK, ARK0);
    expect_out("ark_done_hi", SEL_ARK_DONE, 1);
    tick();
    ark_en = 1'b0; ark_state_in = '1; ark_key_in = '0;
    expect_out("ark_hold", SEL_ARK, ARK0);
    expect_out("ark_done_lo", SEL_ARK_DONE, 0);
    tick();

    // Key expansion chain, each round fed from the previous registered key.
    kexp_en = 1'b1; kexp_key_in = KEY0; kexp_num = 4'd1;
    expect_out("kexp_r1", SEL_KEXP, KEY1);
    tick();
    for (int r = 2; r <= 10; r++) begin
      kexp_key_in = kexp_out;
      kexp_num = 4'(r);
      tick();
    end
    check("kexp_r10", kexp_out, KEY10);
    kexp_en = 1'b0; kexp_key_in = KEY0; kexp_num = 4'd1;
    expect_out("kexp_hold", SEL_KEXP, KEY10);
    tick();
    kexp_en = 1'b1; kexp_key_in = PT; kexp_num = 4'd0;
    expect_out("kexp_num0", SEL_KEXP, PT);
    tick();
    kexp_key_in = KEY1; kexp_num = 4'd12;
    expect_out("kexp_num12", SEL_KEXP, KEY1);
    tick();
    kexp_en = 1'b0;

    // MixColumns: full state, then per-column vectors including fixed points.
    mc_en = 1'b1; mc_in = MC_I;
    expect_out("mc_val", SEL_MC, MC_O);
    expect_out("mc_done_hi", SEL_MC_DONE, 1);
    tick();
    mc_in = COL_I;
    expect_out("mc_cols", SEL_MC, COL_O);
    expect_out("mc_done_held", SEL_MC_DONE, 1);
    tick();
    mc_en = 1'b0; mc_in = MC_I;
    expect_out("mc_hold", SEL_MC, COL_O);
    expect_out("mc_done_lo", SEL_MC_DONE, 0);
    tick();

    // All three sub-operations enabled together.
    ark_en = 1'b1; ark_state_in = MC_O; ark_key_in = KEY1;
    kexp_en = 1'b1; kexp_key_in = KEY0; kexp_num = 4'd1;
    mc_en = 1'b1; mc_in = MC_I;
    expect_out("comb_ark", SEL_ARK, RND1);
    expect_out("comb_ark_done", SEL_ARK_DONE, 1);
    expect_out("comb_kexp", SEL_KEXP, KEY1);
    expect_out("comb_mc", SEL_MC, MC_O);
    expect_out("comb_mc_done", SEL_MC_DONE, 1);
    tick();

    // Reset wins over every enable, and the units restart cleanly after it.
    reset = 1'b1;
    expect_out("mid_rst_ark", SEL_ARK, '0);
    expect_out("mid_rst_ark_done", SEL_ARK_DONE, 0);
    expect_out("mid_rst_kexp", SEL_KEXP, '0);
    expect_out("mid_rst_mc", SEL_MC, '0);
    expect_out("mid_rst_mc_done", SEL_MC_DONE, 0);
    tick();
    reset = 1'b0;
    expect_out("post_rst_ark", SEL_ARK, RND1);
    expect_out("post_rst_ark_done", SEL_ARK_DONE, 1);
    expect_out("post_rst_kexp", SEL_KEXP, KEY1);
    expect_out("post_rst_mc", SEL_MC, MC_O);
    expect_out("post_rst_mc_done", SEL_MC_DONE, 1);
    tick();

    ark_en = 1'b0; kexp_en = 1'b0; mc_en = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
